// File: rtl/motion_bbox_tracker.sv
// -----------------------------------------------------------------------------
// motion_bbox_tracker
//   Consumes the per-pixel motion flag stream from the motion-detection stage.
//   Builds a per-frame bounding box and motion-pixel count. A pixel is only
//   counted once it is part of a horizontal run of at least MIN_RUN motion
//   pixels. One result is published per frame for the overlay and tracking
//   logic downstream.
//
// Ports
//   CLOCK_50      in   system clock, all logic on posedge
//   reset         in   synchronous active-high reset
//   pix_valid     in   pixel strobe
//   pix_x, pix_y  in   pixel coordinate
//   pix_motion    in   motion flag for this pixel
//   result_valid  out  one-cycle pulse, result outputs updated this cycle
//   motion_found  out  count >= MIN_PIXELS for the published frame
//   bbox_x0/x1    out  leftmost / rightmost counted x (0 when !motion_found)
//   bbox_y0/y1    out  top / bottom counted y (0 when !motion_found)
//   motion_count  out  filtered motion pixels in the published frame
// -----------------------------------------------------------------------------
module motion_bbox_tracker #(
    parameter int X_W        = 9,
    parameter int Y_W        = 8,
    parameter int MIN_RUN    = 2,
    parameter int MIN_PIXELS = 64,
    parameter int CNT_W      = 17
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [X_W-1:0]   pix_x,
    input  logic [Y_W-1:0]   pix_y,
    input  logic             pix_motion,
    output logic             result_valid,
    output logic             motion_found,
    output logic [X_W-1:0]   bbox_x0,
    output logic [X_W-1:0]   bbox_x1,
    output logic [Y_W-1:0]   bbox_y0,
    output logic [Y_W-1:0]   bbox_y1,
    output logic [CNT_W-1:0] motion_count
);

    localparam logic [1:0] ST_SYNC    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

    localparam int         CW1       = CNT_W + 1;
    localparam logic [3:0] RUN_SAT   = 4'd15;
    localparam logic [3:0] MIN_RUN_V = 4'(MIN_RUN);
    localparam logic [X_W-1:0]   X_ONE    = X_W'(1);
    localparam logic [X_W-1:0]   RUN_BACK = X_W'(MIN_RUN - 1);
    localparam logic [X_W-1:0]   X_EMPTY  = '1;
    localparam logic [Y_W-1:0]   Y_EMPTY  = '1;
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CW1-1:0]   MIN_PIX_V = CW1'(MIN_PIXELS);
    localparam logic [CW1-1:0]   INC_FIRST = CW1'(MIN_RUN);
    localparam logic [CW1-1:0]   INC_ONE   = CW1'(1);

    logic [1:0]       state_q,  state_d;
    logic [X_W-1:0]   last_x_q, last_x_d;
    logic [Y_W-1:0]   last_y_q, last_y_d;
    logic [3:0]       run_len_q, run_len_d;

    // Frame accumulators; empty sentinel is x0/y0 = max, x1/y1 = 0, any = 0.
    logic [X_W-1:0]   acc_x0_q, acc_x0_d, acc_x1_q, acc_x1_d;
    logic [Y_W-1:0]   acc_y0_q, acc_y0_d, acc_y1_q, acc_y1_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             acc_any_q, acc_any_d;

    // Published result holding registers.
    logic             found_q, found_d;
    logic [X_W-1:0]   out_x0_q, out_x0_d, out_x1_q, out_x1_d;
    logic [Y_W-1:0]   out_y0_q, out_y0_d, out_y1_q, out_y1_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic             boundary, cont, counted, first_hit, found_now;
    logic [3:0]       run_new;
    logic [X_W-1:0]   x_lo, base_x0, base_x1;
    logic [Y_W-1:0]   base_y0, base_y1;
    logic [CNT_W-1:0] base_cnt;
    logic             base_any;
    logic [CW1-1:0]   cnt_sum;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path infers a latch.
        state_d   = state_q;
        last_x_d  = last_x_q;
        last_y_d  = last_y_q;
        run_len_d = run_len_q;
        acc_x0_d  = acc_x0_q;
        acc_x1_d  = acc_x1_q;
        acc_y0_d  = acc_y0_q;
        acc_y1_d  = acc_y1_q;
        acc_cnt_d = acc_cnt_q;
        acc_any_d = acc_any_q;
        found_d   = found_q;
        out_x0_d  = out_x0_q;
        out_x1_d  = out_x1_q;
        out_y0_d  = out_y0_q;
        out_y1_d  = out_y1_q;
        out_cnt_d = out_cnt_q;

        boundary = pix_valid && (pix_y < last_y_q);
        cont     = pix_motion && (pix_y == last_y_q) && (pix_x == last_x_q + X_ONE);

        if (cont)
            run_new = (run_len_q == RUN_SAT) ? RUN_SAT : run_len_q + 4'd1;
        else
            run_new = pix_motion ? 4'd1 : 4'd0;

        counted = (run_new >= MIN_RUN_V);
        // The pixel that completes a run also accounts for the MIN_RUN-1
        // pixels before it; a run already past the threshold adds one.
        first_hit = counted && !(cont && (run_len_q >= MIN_RUN_V));
        x_lo      = first_hit ? pix_x - RUN_BACK : pix_x;

        // The boundary pixel is the first pixel of the new frame, so it is
        // folded into freshly emptied accumulators rather than the old ones.
        base_x0  = boundary ? X_EMPTY : acc_x0_q;
        base_x1  = boundary ? '0      : acc_x1_q;
        base_y0  = boundary ? Y_EMPTY : acc_y0_q;
        base_y1  = boundary ? '0      : acc_y1_q;
        base_cnt = boundary ? '0      : acc_cnt_q;
        base_any = boundary ? 1'b0    : acc_any_q;
        cnt_sum  = {1'b0, base_cnt} + (first_hit ? INC_FIRST : INC_ONE);

        found_now = acc_any_q && ({1'b0, acc_cnt_q} >= MIN_PIX_V);

        if (pix_valid) begin
            last_x_d  = pix_x;
            last_y_d  = pix_y;
            run_len_d = run_new;
            acc_x0_d  = base_x0;
            acc_x1_d  = base_x1;
            acc_y0_d  = base_y0;
            acc_y1_d  = base_y1;
            acc_cnt_d = base_cnt;
            acc_any_d = base_any;
            if (counted) begin
                acc_x0_d  = (x_lo  < base_x0) ? x_lo  : base_x0;
                acc_x1_d  = (pix_x > base_x1) ? pix_x : base_x1;
                acc_y0_d  = (pix_y < base_y0) ? pix_y : base_y0;
                acc_y1_d  = (pix_y > base_y1) ? pix_y : base_y1;
                acc_cnt_d = cnt_sum[CNT_W] ? CNT_SAT : cnt_sum[CNT_W-1:0];
                acc_any_d = 1'b1;
            end
        end

        case (state_q)
            ST_SYNC: begin
                if (boundary)
                    state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (boundary) begin
                    state_d   = ST_PUBLISH;
                    found_d   = found_now;
                    out_cnt_d = acc_cnt_q;
                    out_x0_d  = found_now ? acc_x0_q : '0;
                    out_x1_d  = found_now ? acc_x1_q : '0;
                    out_y0_d  = found_now ? acc_y0_q : '0;
                    out_y1_d  = found_now ? acc_y1_q : '0;
                end
            end
            ST_PUBLISH: state_d = ST_ACCUM;
            default:    state_d = ST_SYNC;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= ST_SYNC;
            last_x_q  <= '0;
            last_y_q  <= '0;
            run_len_q <= '0;
            acc_x0_q  <= X_EMPTY;
            acc_x1_q  <= '0;
            acc_y0_q  <= Y_EMPTY;
            acc_y1_q  <= '0;
            acc_cnt_q <= '0;
            acc_any_q <= 1'b0;
            found_q   <= 1'b0;
            out_x0_q  <= '0;
            out_x1_q  <= '0;
            out_y0_q  <= '0;
            out_y1_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_x_q  <= last_x_d;
            last_y_q  <= last_y_d;
            run_len_q <= run_len_d;
            acc_x0_q  <= acc_x0_d;
            acc_x1_q  <= acc_x1_d;
            acc_y0_q  <= acc_y0_d;
            acc_y1_q  <= acc_y1_d;
            acc_cnt_q <= acc_cnt_d;
            acc_any_q <= acc_any_d;
            found_q   <= found_d;
            out_x0_q  <= out_x0_d;
            out_x1_q  <= out_x1_d;
            out_y0_q  <= out_y0_d;
            out_y1_q  <= out_y1_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign result_valid = (state_q == ST_PUBLISH);
    assign motion_found = found_q;
    assign bbox_x0      = out_x0_q;
    assign bbox_x1      = out_x1_q;
    assign bbox_y0      = out_y0_q;
    assign bbox_y1      = out_y1_q;
    assign motion_count = out_cnt_q;

endmodule

// File: tb/tb_motion_bbox_tracker.sv
// -----------------------------------------------------------------------------
// tb_motion_bbox_tracker
//   Drives rectangular scan windows of pixels into two tracker instances:
//   A (defaults, CNT_W=17, MIN_PIXELS=64) and B (CNT_W=16, MIN_PIXELS=1, so
//   bbox values stay visible for small frames). Each frame's expected result
//   is derived from a run-length scan of the frame bitmap and queued; a
//   monitor pops and compares on every result pulse.
// -----------------------------------------------------------------------------
module tb_motion_bbox_tracker;

    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int MIN_RUN  = 2;
    localparam int MINPIX_A = 64;
    localparam int CNT_A    = 17;
    localparam int MINPIX_B = 1;
    localparam int CNT_B    = 16;

    localparam int P_ZERO  = 0;
    localparam int P_BLOCK = 1;
    localparam int P_CHECK = 2;
    localparam int P_T4    = 3;
    localparam int P_T4B   = 4;
    localparam int P_SOLID = 5;

    typedef struct {
        int cnt;
        int x0;
        int x1;
        int y0;
        int y1;
    } exp_t;

    logic             clk        = 1'b0;
    logic             reset      = 1'b1;
    logic             pix_valid  = 1'b0;
    logic [X_W-1:0]   pix_x      = '0;
    logic [Y_W-1:0]   pix_y      = '0;
    logic             pix_motion = 1'b0;

    logic             a_rv, a_found, b_rv, b_found;
    logic [X_W-1:0]   a_x0, a_x1, b_x0, b_x1;
    logic [Y_W-1:0]   a_y0, a_y1, b_y0, b_y1;
    logic [CNT_A-1:0] a_cnt;
    logic [CNT_B-1:0] b_cnt;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   frame_idx = 0;

    always #10 clk = ~clk;

    motion_bbox_tracker #(.X_W(X_W), .Y_W(Y_W), .MIN_RUN(MIN_RUN),
                          .MIN_PIXELS(MINPIX_A), .CNT_W(CNT_A)) dut_a (
        .CLOCK_50(clk), .reset(reset), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_motion(pix_motion), .result_valid(a_rv),
        .motion_found(a_found), .bbox_x0(a_x0), .bbox_x1(a_x1),
        .bbox_y0(a_y0), .bbox_y1(a_y1), .motion_count(a_cnt)
    );

    motion_bbox_tracker #(.X_W(X_W), .Y_W(Y_W), .MIN_RUN(MIN_RUN),
                          .MIN_PIXELS(MINPIX_B), .CNT_W(CNT_B)) dut_b (
        .CLOCK_50(clk), .reset(reset), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_motion(pix_motion), .result_valid(b_rv),
        .motion_found(b_found), .bbox_x0(b_x0), .bbox_x1(b_x1),
        .bbox_y0(b_y0), .bbox_y1(b_y1), .motion_count(b_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic bit motion_at(input int pat, input int x, input int y);
        case (pat)
            P_BLOCK: return (x >= 100 && x <= 119 && y >= 50 && y <= 59);
            P_CHECK: return ((x + y) % 2) == 0;
            P_T4:    return (y == 239 && x >= 318);
            P_T4B:   return (y == 0) ? (x <= 1) : 1'b1;
            P_SOLID: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Whole-run view: every maximal horizontal run of length >= MIN_RUN
    // contributes all of its pixels and its full extent.
    function automatic exp_t model_frame(input int xa, input int xb, input int ya,
                                         input int yb, input int pat);
        exp_t e;
        int   run;
        int   start;
        e.cnt = 0; e.x0 = 1 << 30; e.x1 = -1; e.y0 = 1 << 30; e.y1 = -1;
        for (int y = ya; y <= yb; y++) begin
            run   = 0;
            start = 0;
            for (int x = xa; x <= xb + 1; x++) begin
                if (x <= xb && motion_at(pat, x, y)) begin
                    if (run == 0) start = x;
                    run++;
                end else begin
                    if (run >= MIN_RUN) begin
                        e.cnt += run;
                        if (start < e.x0)         e.x0 = start;
                        if (start + run - 1 > e.x1) e.x1 = start + run - 1;
                        if (y < e.y0)             e.y0 = y;
                        if (y > e.y1)             e.y1 = y;
                    end
                    run = 0;
                end
            end
        end
        return e;
    endfunction

    task automatic check_reset_state(input string pfx);
        check({pfx, "_a_rv"},    a_rv,    0);
        check({pfx, "_a_found"}, a_found, 0);
        check({pfx, "_a_cnt"},   a_cnt,   0);
        check({pfx, "_a_x0"},    a_x0,    0);
        check({pfx, "_a_y1"},    a_y1,    0);
        check({pfx, "_b_rv"},    b_rv,    0);
        check({pfx, "_b_found"}, b_found, 0);
        check({pfx, "_b_cnt"},   b_cnt,   0);
        check({pfx, "_b_x1"},    b_x1,    0);
        check({pfx, "_b_y0"},    b_y0,    0);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        pix_valid  = 1'b0;
        pix_x      = X_W'($urandom_range(511));
        pix_y      = Y_W'($urandom_range(255));
        pix_motion = 1'($urandom_range(1));
    endtask

    // Scans a window row-major. reset_at >= 0 pulses reset before that pixel
    // index; is_flush marks a trailing frame that is never published.
    task automatic drive_frame(input int xa, input int xb, input int ya, input int yb,
                               input int pat, input bit gaps, input int reset_at,
                               input bit is_flush);
        int n = 0;
        frame_idx++;
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                if (n == reset_at) begin
                    @(posedge clk); #1;
                    pix_valid = 1'b0;
                    reset     = 1'b1;
                    @(posedge clk); #1;
                    check_reset_state("midrst");
                    reset     = 1'b0;
                    frame_idx = 1;
                end
                if (gaps && $urandom_range(3) == 0)
                    repeat ($urandom_range(3, 1)) idle_cycle();
                @(posedge clk); #1;
                pix_valid  = 1'b1;
                pix_x      = X_W'(x);
                pix_y      = Y_W'(y);
                pix_motion = motion_at(pat, x, y);
                n++;
            end
        end
        if (frame_idx >= 2 && !is_flush)
            exp_q.push_back(model_frame(xa, xb, ya, yb, pat));
    endtask

    always @(negedge clk) begin
        if (!reset && (a_rv || b_rv)) begin
            check("pulse_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("a_rv", a_rv, 1);
                check("b_rv", b_rv, 1);
                check("a_found", a_found, mon_e.cnt >= MINPIX_A);
                check("a_cnt", a_cnt, (mon_e.cnt > 131071) ? 131071 : mon_e.cnt);
                check("a_x0", a_x0, (mon_e.cnt >= MINPIX_A) ? mon_e.x0 : 0);
                check("a_x1", a_x1, (mon_e.cnt >= MINPIX_A) ? mon_e.x1 : 0);
                check("a_y0", a_y0, (mon_e.cnt >= MINPIX_A) ? mon_e.y0 : 0);
                check("a_y1", a_y1, (mon_e.cnt >= MINPIX_A) ? mon_e.y1 : 0);
                check("b_found", b_found, mon_e.cnt >= MINPIX_B);
                check("b_cnt", b_cnt, (mon_e.cnt > 65535) ? 65535 : mon_e.cnt);
                check("b_x0", b_x0, (mon_e.cnt >= MINPIX_B) ? mon_e.x0 : 0);
                check("b_x1", b_x1, (mon_e.cnt >= MINPIX_B) ? mon_e.x1 : 0);
                check("b_y0", b_y0, (mon_e.cnt >= MINPIX_B) ? mon_e.y0 : 0);
                check("b_y1", b_y1, (mon_e.cnt >= MINPIX_B) ? mon_e.y1 : 0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        reset = 1'b0;

        // All-zero frames: first boundary only syncs, later ones publish zeros.
        repeat (3) drive_frame(0, 15, 50, 57, P_ZERO, 1'b0, -1, 1'b0);
        // Solid 20x10 block with idle gaps sprinkled in.
        drive_frame(90, 129, 45, 64, P_BLOCK, 1'b1, -1, 1'b0);
        // Checkerboard: no two horizontally adjacent motion pixels.
        drive_frame(0, 99, 0, 49, P_CHECK, 1'b0, -1, 1'b0);
        // Run of 2 at the frame's last pixels, then a motion boundary pixel.
        drive_frame(316, 319, 0, 239, P_T4, 1'b0, -1, 1'b0);
        drive_frame(0, 9, 0, 3, P_T4B, 1'b0, -1, 1'b0);
        // Reset after 100 counted pixels; the next frame is discarded.
        drive_frame(0, 19, 0, 9, P_SOLID, 1'b0, 100, 1'b0);
        drive_frame(0, 19, 0, 9, P_SOLID, 1'b1, -1, 1'b0);
        // Full frame: 76800 pixels saturates the 16-bit counter.
        drive_frame(0, 319, 0, 239, P_SOLID, 1'b0, -1, 1'b0);
        // Trailing frame whose boundary publishes the full-frame result.
        drive_frame(0, 3, 0, 1, P_ZERO, 1'b0, -1, 1'b1);

        @(posedge clk); #1;
        pix_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
